// File: rtl/alu_datapath_pkg.sv
// alu_datapath_pkg
// Shared definitions for the microcoded execution datapath:
//   - control word width and field bit positions
//   - ALU opcode encodings (OP_ADD..OP_SHR)
//   - register file geometry
//   - packed view of the 17-bit control word
package alu_datapath_pkg;

   localparam int CW_W      = 17;
   localparam int NUM_REGS  = 4;
   localparam int REG_IDX_W = 2;
   localparam int IMM_W     = 7;

   // Field bit positions within ControlBus.
   localparam int LD_IMM_BIT = 16;
   localparam int OP_HI      = 15;
   localparam int OP_LO      = 13;
   localparam int SRC_A_HI   = 12;
   localparam int SRC_A_LO   = 11;
   localparam int SRC_B_HI   = 10;
   localparam int SRC_B_LO   = 9;
   localparam int DST_HI     = 8;
   localparam int DST_LO     = 7;
   localparam int WE_BIT     = 6;
   localparam int FE_BIT     = 5;
   localparam int OUT_LD_BIT = 4;
   localparam int IN_LD_BIT  = 3;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_e;

   // Field order mirrors the bit positions above, MSB first.
   typedef struct packed {
      logic                 ld_imm;
      op_e                  op;
      logic [REG_IDX_W-1:0] src_a;
      logic [REG_IDX_W-1:0] src_b;
      logic [REG_IDX_W-1:0] dst;
      logic                 we;
      logic                 fe;
      logic                 out_ld;
      logic                 in_ld;
      logic [2:0]           rsvd;
   } cw_t;

   // The immediate overlays OP/SRC_A/SRC_B, i.e. ControlBus[15:9].
   function automatic logic [IMM_W-1:0] cw_imm(input cw_t cw);
      return {cw.op, cw.src_a, cw.src_b};
   endfunction

endpackage

// File: rtl/alu_datapath_if.sv
// alu_datapath_if
// Sequencer <-> datapath bus.
//   ControlBus     : microcode word, sequencer -> datapath
//   data_in        : external operand, sequencer side -> datapath
//   data_out       : registered output port
//   data_out_valid : one-cycle pulse per data_out update
//   CarryFlag/ZeroFlag : registered flags back to the sequencer
// master = sequencer / environment side, slave = datapath.
interface alu_datapath_if #(
   parameter int DATA_W = 8
);
   import alu_datapath_pkg::*;

   logic [CW_W-1:0]   ControlBus;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              data_out_valid;
   logic              CarryFlag;
   logic              ZeroFlag;

   modport master (
      output ControlBus, data_in,
      input  data_out, data_out_valid, CarryFlag, ZeroFlag
   );

   modport slave (
      input  ControlBus, data_in,
      output data_out, data_out_valid, CarryFlag, ZeroFlag
   );

endinterface

// File: rtl/alu_datapath_alu_core.sv
// alu_core
// Purely combinational ALU.
//   a, b   : operands (DATA_W)
//   op     : operation select (op_e)
//   result : DATA_W result, truncated
//   carry  : ADD carry-out, SUB borrow, shifted-out bit for shifts, else 0
module alu_core
   import alu_datapath_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  op_e               op,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   // One extra bit catches ADD carry-out and SUB borrow (wraparound sets it).
   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      unique case (op)
         OP_ADD: begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
         OP_SUB: begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
         OP_AND: result = a & b;
         OP_OR : result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_SHL: begin result = {a[DATA_W-2:0], 1'b0}; carry = a[DATA_W-1]; end
         OP_SHR: begin result = {1'b0, a[DATA_W-1:1]}; carry = a[0];        end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_datapath.sv
// alu_datapath
// One-word-per-clock execution datapath behind the microprogram sequencer.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears registers, flags and output
//   bus   : alu_datapath_if.slave (ControlBus, data_in in; data_out,
//           data_out_valid, CarryFlag, ZeroFlag out)
// Holds R0..R3, Carry/Zero flags and the output register. An all-zero
// control word has WE=FE=OUT_LD=0 and therefore changes nothing.
module alu_datapath
   import alu_datapath_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic          clk,
   input  logic          reset,
   alu_datapath_if.slave bus
);

   cw_t                               cw;
   logic [NUM_REGS-1:0][DATA_W-1:0]   rf;
   logic [DATA_W-1:0]                 op_a, op_b;
   logic [DATA_W-1:0]                 alu_res;
   logic                              alu_c;
   logic [DATA_W-1:0]                 wr_data;
   logic                              wr_c;
   logic                              unused_rsvd;

   assign cw          = cw_t'(bus.ControlBus);
   assign unused_rsvd = ^cw.rsvd;

   assign op_a = rf[cw.src_a];
   assign op_b = rf[cw.src_b];

   alu_core #(.DATA_W(DATA_W)) u_alu (
      .a      (op_a),
      .b      (op_b),
      .op     (cw.op),
      .result (alu_res),
      .carry  (alu_c)
   );

   // Write data priority: immediate, then external input, then ALU.
   // Immediate and input loads always clear carry.
   always_comb begin
      wr_data = alu_res;
      wr_c    = alu_c;
      if (cw.ld_imm) begin
         wr_data = {{(DATA_W-IMM_W){1'b0}}, cw_imm(cw)};
         wr_c    = 1'b0;
      end else if (cw.in_ld) begin
         wr_data = bus.data_in;
         wr_c    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (cw.we) begin
         rf[cw.dst] <= wr_data;
      end
   end

   // Zero reflects the selected write data even when WE=0 (compare/test).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.CarryFlag <= 1'b0;
         bus.ZeroFlag  <= 1'b0;
      end else if (cw.fe) begin
         bus.CarryFlag <= wr_c;
         bus.ZeroFlag  <= (wr_data == '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.data_out       <= '0;
         bus.data_out_valid <= 1'b0;
      end else begin
         bus.data_out_valid <= cw.out_ld;
         if (cw.out_ld) bus.data_out <= wr_data;
      end
   end

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath
// Directed vectors with hand-computed expectations. Register contents are
// observed through the output port using an OR Rx,Rx / OUT_LD read word.
module tb_alu_datapath;
   import alu_datapath_pkg::*;

   localparam int DATA_W = 8;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   alu_datapath_if #(.DATA_W(DATA_W)) bus ();

   alu_datapath #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
   endtask

   function automatic logic [16:0] w_imm(input logic [6:0] v, input logic [1:0] d);
      return {1'b1, v, d, 1'b1, 6'b0};
   endfunction

   function automatic logic [16:0] w_alu(input logic [2:0] op, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] d,
                                         input logic we, input logic fe, input logic ol);
      return {1'b0, op, a, b, d, we, fe, ol, 1'b0, 3'b0};
   endfunction

   function automatic logic [16:0] w_in(input logic [1:0] d, input logic fe, input logic ol);
      return {8'b0, d, 1'b1, fe, ol, 1'b1, 3'b0};
   endfunction

   // Drive a word, let one rising edge execute it, sample 1 time unit later.
   task automatic exec(input logic [16:0] cw, input logic [7:0] din);
      bus.ControlBus = cw;
      bus.data_in    = din;
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] r, input logic [7:0] exp);
      exec(w_alu(OP_OR, r, r, 2'd0, 1'b0, 1'b0, 1'b1), 8'h00);
      chk(tag, bus.data_out, exp);
   endtask

   task automatic flags_chk(input string tag, input logic c, input logic z);
      chk({tag, "_c"}, bus.CarryFlag, c);
      chk({tag, "_z"}, bus.ZeroFlag, z);
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      reset = 1'b0;
      bus.ControlBus = '0;
      bus.data_in    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", bus.data_out, 8'h00);
      chk("rst_vld", bus.data_out_valid, 1'b0);
      flags_chk("rst", 1'b0, 1'b0);
      @(negedge clk) reset = 1'b1;

      // Load R1, then assert reset asynchronously mid-cycle.
      exec(w_imm(7'h55, 2'd1), 8'h00);
      rd_chk("r1_pre", 2'd1, 8'h55);
      chk("r1_pre_vld", bus.data_out_valid, 1'b1);
      bus.ControlBus = w_imm(7'h22, 2'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_dout", bus.data_out, 8'h00);
      chk("async_vld", bus.data_out_valid, 1'b0);
      @(posedge clk); #1;
      chk("hold_dout", bus.data_out, 8'h00);
      bus.ControlBus = '0;
      @(negedge clk) reset = 1'b1;
      rd_chk("r1_post", 2'd1, 8'h00);
      chk("first_vld", bus.data_out_valid, 1'b1);

      // 0x7F + 0x01 -> 0x80
      exec(w_imm(7'h7F, 2'd0), 8'h00);
      exec(w_imm(7'h01, 2'd1), 8'h00);
      exec(w_alu(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 1'b1), 8'h00);
      chk("add_dout", bus.data_out, 8'h80);
      chk("add_vld", bus.data_out_valid, 1'b1);
      flags_chk("add", 1'b0, 1'b0);
      exec('0, 8'h00);
      chk("add_vld_drop", bus.data_out_valid, 1'b0);
      chk("add_dout_hold", bus.data_out, 8'h80);
      rd_chk("add_r2", 2'd2, 8'h80);

      // 0xFF + 0x01 -> 0x00, C=1, Z=1 (0xFF built as NOT 0)
      exec(w_imm(7'h00, 2'd0), 8'h00);
      exec(w_alu(OP_NOT, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0), 8'h00);
      exec(w_alu(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0), 8'h00);
      flags_chk("addc", 1'b1, 1'b1);
      exec(w_imm(7'h05, 2'd3), 8'h00);
      flags_chk("fe0_hold", 1'b1, 1'b1);
      rd_chk("addc_r2", 2'd2, 8'h00);
      rd_chk("not_r0", 2'd0, 8'hFF);

      // SUB 3-5 -> 0xFE borrow; SUB 5-5 -> 0, no borrow
      exec(w_imm(7'h03, 2'd0), 8'h00);
      exec(w_imm(7'h05, 2'd1), 8'h00);
      exec(w_alu(OP_SUB, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 1'b1), 8'h00);
      chk("sub_dout", bus.data_out, 8'hFE);
      flags_chk("sub", 1'b1, 1'b0);
      exec(w_imm(7'h05, 2'd0), 8'h00);
      exec(w_alu(OP_SUB, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 1'b1), 8'h00);
      chk("sub0_dout", bus.data_out, 8'h00);
      flags_chk("sub0", 1'b0, 1'b1);

      // Build 0x81 in R0: R1=0x40<<1=0x80, R0 = R1 | 0x01
      exec(w_imm(7'h01, 2'd0), 8'h00);
      exec(w_imm(7'h40, 2'd1), 8'h00);
      exec(w_alu(OP_SHL, 2'd1, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0), 8'h00);
      exec(w_alu(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0), 8'h00);
      exec(w_alu(OP_SHL, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1), 8'h00);
      chk("shl_dout", bus.data_out, 8'h02);
      flags_chk("shl", 1'b1, 1'b0);
      exec(w_alu(OP_SHR, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1), 8'h00);
      chk("shr_dout", bus.data_out, 8'h40);
      flags_chk("shr", 1'b1, 1'b0);

      // AND 0xF0 & 0x0F with carry set beforehand -> C cleared, Z=1
      exec(w_imm(7'h0F, 2'd0), 8'h00);
      exec(w_imm(7'h78, 2'd1), 8'h00);
      exec(w_alu(OP_SHL, 2'd1, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0), 8'h00);
      exec(w_alu(OP_AND, 2'd1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1), 8'h00);
      chk("and_dout", bus.data_out, 8'h00);
      flags_chk("and", 1'b0, 1'b1);
      // XOR 0xF0^0x0F = 0xFF, then compare-only XOR R0,R0 (WE=0)
      exec(w_alu(OP_XOR, 2'd1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0), 8'h00);
      flags_chk("xor", 1'b0, 1'b0);
      exec(w_alu(OP_XOR, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0), 8'h00);
      flags_chk("cmp", 1'b0, 1'b1);
      rd_chk("cmp_r2", 2'd2, 8'hFF);

      // IN_LD alone, then IN_LD together with LD_IMM
      exec(w_in(2'd3, 1'b1, 1'b1), 8'hA5);
      chk("inld_dout", bus.data_out, 8'hA5);
      flags_chk("inld", 1'b0, 1'b0);
      exec(w_imm(7'h12, 2'd3) | 17'h00018, 8'hA5);
      chk("immwin_dout", bus.data_out, 8'h12);
      rd_chk("immwin_r3", 2'd3, 8'h12);

      // Set flags to a distinctive state, then idle; reserved bits ignored.
      exec(w_in(2'd3, 1'b1, 1'b1), 8'h00);
      flags_chk("inld0", 1'b0, 1'b1);
      exec(w_alu(OP_ADD, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1), 8'h00);
      chk("pre_idle_dout", bus.data_out, 8'h0F);
      for (int i = 0; i < 10; i++) begin
         exec((i % 2 == 0) ? 17'h00000 : 17'h00007, 8'h5A);
         chk($sformatf("idle_vld%0d", i), bus.data_out_valid, 1'b0);
      end
      chk("idle_dout", bus.data_out, 8'h0F);
      flags_chk("idle", 1'b0, 1'b1);
      rd_chk("idle_r0", 2'd0, 8'h0F);
      rd_chk("idle_r3", 2'd3, 8'h00);
      chk("b2b_vld", bus.data_out_valid, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_datapath.md
# alu_datapath

Execution datapath driven by the 17-bit microcode control word from the microprogram sequencer. Holds a 4-entry register file, a single-cycle ALU, the Carry/Zero flag registers fed back to the sequencer for conditional jumps, and a registered output port. Every control word executes in one clock; an all-zero word is a NOP, so sequencer jump words never disturb state.

## Interface
- DATA_W, 8, datapath and register width (≥8).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ControlBus  in  17  microcode control word, valid every cycle.
- data_in  in  DATA_W  external operand, sampled when IN_LD=1.
- data_out  out  DATA_W  registered output port.
- data_out_valid  out  1  one-cycle pulse when data_out updates.
- CarryFlag  out  1  registered carry flag, to sequencer.
- ZeroFlag  out  1  registered zero flag, to sequencer.

## Operation
- Control fields: [16] LD_IMM, [15:13] OP, [12:11] SRC_A, [10:9] SRC_B, [8:7] DST, [6] WE, [5] FE, [4] OUT_LD, [3] IN_LD, [2:0] reserved (ignored).
- Register file R0..R3, DATA_W each; reads combinational, writes at posedge when WE=1 to R[DST].
- Write data priority: LD_IMM > IN_LD > ALU result.
- LD_IMM: value = ControlBus[15:9] zero-extended (0..127); OP/SRC fields ignored.
- OP (A=R[SRC_A], B=R[SRC_B]): 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A by 1, 111 SHR A by 1 (logical). Result truncated to DATA_W.
- Carry rules: ADD = carry-out of DATA_W+1-bit sum; SUB = borrow (1 iff A<B unsigned); SHL = old A[MSB]; SHR = old A[0]; logic ops, LD_IMM, IN_LD = 0.
- Zero = (selected write data == 0), regardless of WE.
- FE=1: both flags load at posedge; FE=0: both hold.
- OUT_LD=1: data_out <= selected write data at posedge; data_out_valid=1 for exactly that following cycle, else 0. Back-to-back OUT_LD gives continuous valid with new data each cycle.
- WE, FE, OUT_LD are independent; any combination legal. WE=0 with FE=1 is a compare/test.
- SRC equal to DST legal: old value read, new value written.

## Timing
- All state updates on rising clk; single-cycle, no stalls, no handshake back-pressure.
- Register write visible on reads in the next cycle (no bypass needed).
- Flags updated by word N are visible to the sequencer while word N+1 is presented, i.e. the sequencer's branch decision on the edge ending word N+1 uses them.
- data_out/data_out_valid change one clock after the OUT_LD word.
- reset low (any time, asynchronous): R0..R3=0, CarryFlag=0, ZeroFlag=0, data_out=0, data_out_valid=0; held while low. First edge after release executes normally. Reset mid-operation discards the in-flight word.
- ControlBus=0: no register, flag, or output change; data_out_valid=0.

## Structure
- Shared package: field bit positions, OP encodings (OP_ADD..OP_SHR), CW_W=17, register count/index width.
- One combinational sub-module alu_core (A, B, OP → result, carry); register file, flags, output register in alu_datapath.

## Test plan
- Reset: drive reset low mid-run after loading R1=0x55 → all outputs 0 and R1 reads 0 after release; first word executes.
- LD_IMM 0x7F to R0, LD_IMM 0x01 to R1, ADD R0+R1→R2 with FE, OUT_LD → data_out=0x80, valid one cycle, C=0, Z=0.
- LD R0=0xFF, R1=0x01, ADD with FE → R2=0x00, C=1, Z=1; next word FE=0 → flags hold.
- SUB R0=0x03, R1=0x05 → 0xFE, C=1, Z=0; SUB equal values (0x05-0x05) → 0x00, C=0, Z=1.
- Shifts: A=0x81, SHL → 0x02, C=1; SHR → 0x40, C=1; AND 0xF0&0x0F with FE → Z=1, C=0.
- IN_LD with data_in=0xA5 to R3 and LD_IMM simultaneously set → immediate wins; all-zero ControlBus for 10 cycles → no state change, valid stays 0.
